// File: rtl/pb_pkg.sv
// Shared constants, debug bundle layout and width helper
// for the multi-channel push-button conditioner.
package pb_pkg;

  localparam logic PRESSED  = 1'b1;
  localparam logic RELEASED = 1'b0;

  localparam int DBG_SYNC  = 7;
  localparam int DBG_STATE = 6;
  localparam int DBG_CNTNZ = 5;
  localparam int DBG_LONG  = 4;
  localparam int DBG_CNT_H = 3;
  localparam int DBG_CNT_L = 0;

  // Field order matches the o_debug bit map, MSB first.
  typedef struct packed {
    logic       sync;
    logic       state;
    logic       cnt_nz;
    logic       long_ph;
    logic [3:0] cnt_lo;
  } pb_dbg_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pb_debounce_channel.sv
// One button: 2-FF sync, polarity fix, stability debounce,
// then long-press / auto-repeat timing on the clean level.
module pb_debounce_channel
  import pb_pkg::*;
#(
  parameter int DELAY      = 16,
  parameter int HOLD       = 1000000,
  parameter int REPEAT     = 250000,
  parameter int ACTIVE_LOW = 1,
  parameter bit DBG_EN     = 1'b0
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_pb,
  output logic    o_state,
  output logic    o_down,
  output logic    o_up,
  output logic    o_long,
  output logic    o_repeat,
  output pb_dbg_t o_dbg
);

  localparam int CW = clog2(DELAY + 1);
  localparam int HW = clog2(HOLD + REPEAT + 1);

  localparam logic [CW-1:0] C_LAST = CW'(DELAY - 1);
  localparam logic [HW:0]   H_LONG = (HW+1)'(HOLD);
  localparam logic [HW:0]   H_WRAP = (HW+1)'(HOLD + REPEAT);

  logic          r_meta;
  logic          r_sync;
  logic          r_state;
  logic [CW-1:0] r_cnt;
  logic          r_down;
  logic          r_up;
  logic [HW-1:0] r_hold;
  logic          r_long_ph;
  logic          r_long;
  logic          r_rep;

  logic          w_norm;
  logic          w_flip;
  logic [HW:0]   w_hnext;
  logic [3:0]    w_cnt_lo;

  assign w_norm  = (ACTIVE_LOW != 0) ? ~i_pb : i_pb;
  assign w_flip  = (r_sync != r_state) && (r_cnt == C_LAST);
  assign w_hnext = {1'b0, r_hold} + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= RELEASED;
      r_sync <= RELEASED;
    end else begin
      r_meta <= w_norm;
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_down  <= 1'b0;
      r_up    <= 1'b0;
    end else begin
      r_down <= w_flip && (r_state == RELEASED);
      r_up   <= w_flip && (r_state == PRESSED);
      if (r_sync == r_state) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_state <= ~r_state;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Counter wraps from HOLD+REPEAT back to HOLD so repeats never end.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_flip || (r_state == RELEASED)) begin
      r_hold    <= '0;
      r_long_ph <= 1'b0;
      r_long    <= 1'b0;
      r_rep     <= 1'b0;
    end else begin
      r_long <= 1'b0;
      r_rep  <= 1'b0;
      if ((REPEAT > 0) && (w_hnext == H_WRAP)) begin
        r_rep  <= 1'b1;
        r_hold <= H_LONG[HW-1:0];
      end else if (w_hnext == H_LONG) begin
        r_long    <= 1'b1;
        r_long_ph <= 1'b1;
        r_hold    <= w_hnext[HW-1:0];
      end else if (!r_long_ph || (REPEAT > 0)) begin
        r_hold <= w_hnext[HW-1:0];
      end
    end
  end

  generate
    if (CW >= 4) begin : g_lo_wide
      assign w_cnt_lo = r_cnt[3:0];
    end else begin : g_lo_narrow
      assign w_cnt_lo = {{(4-CW){1'b0}}, r_cnt};
    end
  endgenerate

  assign o_state  = r_state;
  assign o_down   = r_down;
  assign o_up     = r_up;
  assign o_long   = r_long;
  assign o_repeat = r_rep;

  always_comb begin
    o_dbg = '0;
    if (DBG_EN) begin
      o_dbg.sync    = r_sync;
      o_dbg.state   = r_state;
      o_dbg.cnt_nz  = |r_cnt;
      o_dbg.long_ph = r_long_ph & r_state;
      o_dbg.cnt_lo  = w_cnt_lo;
    end
  end

endmodule

// File: rtl/multi_pb_debouncer.sv
// N independent button conditioners plus a channel-0
// debug bus for bring-up.
module multi_pb_debouncer
  import pb_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DELAY      = 16,
  parameter int HOLD       = 1000000,
  parameter int REPEAT     = 250000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [N_CH-1:0] i_PB,
  output logic [N_CH-1:0] o_PB_state,
  output logic [N_CH-1:0] o_PB_down,
  output logic [N_CH-1:0] o_PB_up,
  output logic [N_CH-1:0] o_PB_long,
  output logic [N_CH-1:0] o_PB_repeat,
  output logic [7:0]      o_debug
);

  pb_dbg_t w_dbg [N_CH];
  pb_dbg_t w_dbg_or;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      pb_debounce_channel #(
        .DELAY      (DELAY),
        .HOLD       (HOLD),
        .REPEAT     (REPEAT),
        .ACTIVE_LOW (ACTIVE_LOW),
        .DBG_EN     (g == 0)
      ) u_ch (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_pb     (i_PB[g]),
        .o_state  (o_PB_state[g]),
        .o_down   (o_PB_down[g]),
        .o_up     (o_PB_up[g]),
        .o_long   (o_PB_long[g]),
        .o_repeat (o_PB_repeat[g]),
        .o_dbg    (w_dbg[g])
      );
    end
  endgenerate

  // Only channel 0 drives its debug bundle; the OR acts as the mux.
  always_comb begin
    w_dbg_or = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_dbg_or = w_dbg_or | w_dbg[i];
    end
  end

  assign o_debug = w_dbg_or;

endmodule

// File: tb/tb_multi_pb_debouncer.sv
// Random + directed stimulus against an event-time reference
// model of the button conditioner.
module tb_multi_pb_debouncer;

  localparam int N      = 4;
  localparam int DELAY  = 4;
  localparam int HOLD   = 20;
  localparam int REPEAT = 5;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic [N-1:0] i_PB = '1;
  logic [N-1:0] o_PB_state;
  logic [N-1:0] o_PB_down;
  logic [N-1:0] o_PB_up;
  logic [N-1:0] o_PB_long;
  logic [N-1:0] o_PB_repeat;
  logic [7:0]   o_debug;

  always #5 i_clk = ~i_clk;

  multi_pb_debouncer #(
    .N_CH       (N),
    .DELAY      (DELAY),
    .HOLD       (HOLD),
    .REPEAT     (REPEAT),
    .ACTIVE_LOW (1)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_PB        (i_PB),
    .o_PB_state  (o_PB_state),
    .o_PB_down   (o_PB_down),
    .o_PB_up     (o_PB_up),
    .o_PB_long   (o_PB_long),
    .o_PB_repeat (o_PB_repeat),
    .o_debug     (o_debug)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: pressed level seen 1 and 2 edges ago, clean level,
  // length of the current run of disagreeing samples, press edge.
  bit      m1 [N];
  bit      m2 [N];
  bit      st [N];
  int      run [N];
  longint  pa [N];
  longint  t = 0;

  logic [N-1:0] e_state, e_down, e_up, e_long, e_rep;
  logic [7:0]   e_dbg;

  task automatic model_step(input logic [N-1:0] pb, input logic rst);
    bit     smp;
    longint c;
    t++;
    e_down = '0;
    e_up   = '0;
    e_long = '0;
    e_rep  = '0;
    for (int ch = 0; ch < N; ch++) begin
      if (rst) begin
        m1[ch]  = 1'b0;
        m2[ch]  = 1'b0;
        st[ch]  = 1'b0;
        run[ch] = 0;
        pa[ch]  = -1;
      end else begin
        smp    = m2[ch];
        m2[ch] = m1[ch];
        m1[ch] = ~pb[ch];
        run[ch] = (smp != st[ch]) ? run[ch] + 1 : 0;
        if (run[ch] == DELAY) begin
          st[ch]  = ~st[ch];
          run[ch] = 0;
          if (st[ch]) begin
            e_down[ch] = 1'b1;
            pa[ch]     = t;
          end else begin
            e_up[ch] = 1'b1;
          end
        end else if (st[ch]) begin
          c = t - pa[ch];
          e_long[ch] = (c == HOLD);
          e_rep[ch]  = (REPEAT > 0) && (c > HOLD) &&
                       ((c - HOLD) % REPEAT == 0);
        end
      end
      e_state[ch] = st[ch];
    end
    e_dbg = {m2[0], st[0], run[0] != 0,
             st[0] && (t - pa[0] >= HOLD), 4'(run[0])};
  endtask

  task automatic tick(input logic [N-1:0] pb, input logic rst);
    i_PB    = pb;
    i_reset = rst;
    @(posedge i_clk);
    model_step(pb, rst);
    #1;
    check("state",  8'(o_PB_state),  8'(e_state));
    check("down",   8'(o_PB_down),   8'(e_down));
    check("up",     8'(o_PB_up),     8'(e_up));
    check("long",   8'(o_PB_long),   8'(e_long));
    check("repeat", 8'(o_PB_repeat), 8'(e_rep));
    check("debug",  o_debug,         e_dbg);
  endtask

  bit           lv [N];
  int           dur [N];
  logic [N-1:0] pb;

  initial begin
    repeat (10) tick(4'hF, 1'b1);
    repeat (3)  tick(4'hF, 1'b0);
    repeat (12) tick(4'hE, 1'b0);
    repeat (12) tick(4'hF, 1'b0);
    repeat (3)  tick(4'hD, 1'b0);
    tick(4'hF, 1'b0);
    repeat (3)  tick(4'hD, 1'b0);
    tick(4'hF, 1'b0);
    repeat (12) tick(4'hD, 1'b0);
    repeat (12) tick(4'hF, 1'b0);
    repeat (60) tick(4'hB, 1'b0);
    repeat (15) tick(4'hF, 1'b0);
    repeat (30) tick(4'h7, 1'b0);
    repeat (2)  tick(4'h7, 1'b1);
    repeat (15) tick(4'h7, 1'b0);
    repeat (12) tick(4'hF, 1'b0);
    repeat (12) tick(4'h6, 1'b0);
    repeat (12) tick(4'hF, 1'b0);

    for (int ch = 0; ch < N; ch++) begin
      lv[ch]  = 1'b0;
      dur[ch] = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (dur[ch] == 0) begin
          lv[ch]  = ~lv[ch];
          dur[ch] = ($urandom_range(0, 3) == 0) ?
                    int'($urandom_range(1, 3)) :
                    int'($urandom_range(5, 70));
        end
        dur[ch]--;
        pb[ch] = ~lv[ch];
      end
      if ($urandom_range(0, 599) == 0) begin
        repeat (2) tick(pb, 1'b1);
      end else begin
        tick(pb, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
